hps_reset_sequencer: RTL
========================

// Module: hps_reset_sequencer
// PURPOSE
//  Consumes 3 level reset requests from the source/probe (bit0 cold, bit1 warm, bit2 debug).
//  Arbitrates them and drives the HPS f2h cold/warm/debug reset-request inputs.
//  Each accepted request produces exactly one active-low pulse of per-type length, then a holdoff.
//  Replaces three independent edge detectors; requests can no longer overlap at the HPS.
// PARAMETERS
//  COLD_PULSE   6     cycles cold_req_n held low (>=1)
//  WARM_PULSE   2     cycles warm_req_n held low (>=1)
//  DEBUG_PULSE  32    cycles debug_req_n held low (>=1)
//  HOLDOFF      1000  idle cycles after any pulse before the next pulse (>=1)
//  CNT_W        16    shared down-counter width; must hold max(all pulse lengths, HOLDOFF)
// PORTS
//  clk            in   1  fabric clock (fpga_clk_50 domain)
//  rst            in   1  synchronous, active-high reset
//  req_in         in   3  level requests {debug,warm,cold}, synchronous to clk
//  cold_req_n     out  1  to f2h_cold_reset_req_reset_n, active low
//  warm_req_n     out  1  to f2h_warm_reset_req_reset_n, active low
//  debug_req_n    out  1  to f2h_debug_reset_req_reset_n, active low
//  busy           out  1  high in PULSE or HOLDOFF
//  active_type    out  2  0 none, 1 cold, 2 warm, 3 debug (type currently pulsing)
// BEHAVIOUR
//  Reset: all *_req_n=1, busy=0, active_type=0, pending=0, state IDLE, edge history prev=3'b111.
//   A request held high through reset does not fire; it must go low, then high.
//  Edge capture: rise[i] = req_in[i] & ~prev[i]; prev<=req_in every cycle.
//   On a rise, pending[i] is set at that clock edge. Duplicate rises on a set pending bit merge.
//  Priority among pending bits: cold > warm > debug.
//  FSM IDLE: if any pending bit is set, load the counter with that type's PULSE-1,
//   clear its pending bit and go to PULSE.
//  FSM PULSE: selected *_req_n=0; counter decrements; at 0, load HOLDOFF-1 and go to HOLDOFF.
//  FSM HOLDOFF: all *_req_n=1; counter decrements; at 0, go to IDLE.
//  Latency: rise sampled at edge k sets pending; the output goes low after edge k+1.
//   It stays low for exactly N_PULSE cycles.
//  Rise while busy (any type, including the active type): latched as pending.
//   It is served in priority order after HOLDOFF; an active pulse is never cut short.
//  Simultaneous rises: all are latched; they are served in priority order, each separated by HOLDOFF.
//  Rise on a bit in the same cycle IDLE clears it: the set wins; the request is served again later.
//  rst mid-pulse: the output returns high at the next edge; pending is discarded.
//  Outputs are registered only; no combinational path from req_in to any output.
// CONFIGURATION
//  `RESET_SEQ_COUNTERS_EN defined:
//   adds output req_cnt[23:0] = {debug,warm,cold} 8-bit counters.
//   Each counter increments once per accepted pulse (IDLE->PULSE), saturates at 255, is cleared by rst.
//  Macro undefined: req_cnt port and its logic are absent; all other behaviour is identical.
// STRUCTURE
//  Package hps_reset_seq_pkg:
//   state encoding (IDLE/PULSE/HOLDOFF).
//   type codes TYPE_NONE/COLD/WARM/DEBUG (2 bits).
//   function pulse_len(type) returning the per-type length.
//  Sub-module hps_reset_req_capture: prev register, rise detect, pending set/clear per bit, priority pick.
//  Top: FSM, single CNT_W down-counter, registered outputs, optional counters.
// TESTING
//  1) After rst, req_in 000->001 -> cold_req_n low for exactly 6 cycles starting 2 edges later;
//     busy high for 6+1000 cycles; active_type=1 only during the pulse.
//  2) req_in=111 during rst, then released -> no pulse.
//     Drop to 000, then 010 -> one warm pulse of 2 cycles.
//  3) req_in 000->111 in one cycle -> cold(6), holdoff 1000, warm(2), holdoff, debug(32),
//     never overlapping; active_type sequence 1,2,3.
//  4) Debug pulse active; toggle bit2 twice and bit0 once -> after holdoff, cold first,
//     then a single debug pulse (duplicates merged).
//  5) Assert rst at cycle 3 of a debug pulse -> debug_req_n=1 at the next edge;
//     no pulse after release; busy=0.
//  6) With RESET_SEQ_COUNTERS_EN defined: 300 warm requests -> req_cnt[15:8]=255, other fields 0.

Source files
------------

// File: rtl/hps_reset_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : hps_reset_seq_pkg
//  Description : Shared definitions for the HPS reset-request sequencer:
//                FSM state encoding, reset-type codes and the per-type
//                pulse-length lookup.
//  Revision    : 1.0 - initial release
// ============================================================================
package hps_reset_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PULSE   = 2'd1,
    ST_HOLDOFF = 2'd2
  } state_t;

  localparam logic [1:0] TYPE_NONE  = 2'd0;
  localparam logic [1:0] TYPE_COLD  = 2'd1;
  localparam logic [1:0] TYPE_WARM  = 2'd2;
  localparam logic [1:0] TYPE_DEBUG = 2'd3;

  // The lengths are module parameters, so the caller hands them in.
  function automatic int unsigned pulse_len(input logic [1:0] typ,
                                            input int unsigned cold_len,
                                            input int unsigned warm_len,
                                            input int unsigned debug_len);
    case (typ)
      TYPE_COLD:  pulse_len = cold_len;
      TYPE_WARM:  pulse_len = warm_len;
      TYPE_DEBUG: pulse_len = debug_len;
      default:    pulse_len = 1;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/hps_reset_req_capture.sv
`default_nettype none
// ============================================================================
//  Module      : hps_reset_req_capture
//  Description : Rising-edge capture of the three level reset requests into
//                sticky pending bits, plus a fixed-priority pick
//                (cold > warm > debug).
//  Ports       : clk, rst      - clock, synchronous active-high reset
//                req_in[2:0]   - level requests {debug,warm,cold}
//                clr[2:0]      - one-hot clear of the bit being served
//                pending[2:0]  - latched requests awaiting service
//                pick[1:0]     - highest-priority pending type code
//  Revision    : 1.0 - initial release
// ============================================================================
module hps_reset_req_capture
  import hps_reset_seq_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] req_in,
  input  logic [2:0] clr,
  output logic [2:0] pending,
  output logic [1:0] pick
);

  logic [2:0] r_prev;
  logic [2:0] r_pending;
  logic [2:0] w_rise;

  assign w_rise = req_in & ~r_prev;

  // History resets to all-ones so a request held through reset needs a
  // fresh low->high transition before it counts.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_prev    <= 3'b111;
      r_pending <= 3'b000;
    end else begin
      r_prev    <= req_in;
      // A rise in the same cycle as the clear wins, so it is served again.
      r_pending <= (r_pending & ~clr) | w_rise;
    end
  end

  always_comb begin
    pick = TYPE_NONE;
    if (r_pending[0])      pick = TYPE_COLD;
    else if (r_pending[1]) pick = TYPE_WARM;
    else if (r_pending[2]) pick = TYPE_DEBUG;
  end

  assign pending = r_pending;

endmodule
`default_nettype wire

// File: rtl/hps_reset_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : hps_reset_sequencer
//  Description : Arbitrates cold/warm/debug reset requests and drives the HPS
//                f2h reset-request inputs with one non-overlapping active-low
//                pulse per accepted request, followed by a holdoff period.
//  Ports       : clk, rst       - clock, synchronous active-high reset
//                req_in[2:0]    - level requests {debug,warm,cold}
//                cold_req_n     - HPS cold reset request, active low
//                warm_req_n     - HPS warm reset request, active low
//                debug_req_n    - HPS debug reset request, active low
//                busy           - high while pulsing or in holdoff
//                active_type    - 0 none, 1 cold, 2 warm, 3 debug
//                req_cnt[23:0]  - {debug,warm,cold} saturating pulse counts
//                                 (only with RESET_SEQ_COUNTERS_EN defined)
//  Config      : `RESET_SEQ_COUNTERS_EN adds the req_cnt port and counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module hps_reset_sequencer
  import hps_reset_seq_pkg::*;
#(
  parameter int unsigned COLD_PULSE  = 6,
  parameter int unsigned WARM_PULSE  = 2,
  parameter int unsigned DEBUG_PULSE = 32,
  parameter int unsigned HOLDOFF     = 1000,
  parameter int unsigned CNT_W       = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  req_in,
  output logic        cold_req_n,
  output logic        warm_req_n,
  output logic        debug_req_n,
  output logic        busy,
  output logic [1:0]  active_type
`ifdef RESET_SEQ_COUNTERS_EN
  ,
  output logic [23:0] req_cnt
`endif
);

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [1:0]       r_type, w_type_nxt;
  logic [2:0]       w_clr;
  logic [1:0]       w_pick;
  logic [2:0]       w_pending;
  logic             w_start;

  hps_reset_req_capture u_capture (
    .clk     (clk),
    .rst     (rst),
    .req_in  (req_in),
    .clr     (w_clr),
    .pending (w_pending),
    .pick    (w_pick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_type  <= TYPE_NONE;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_type  <= w_type_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_type_nxt  = r_type;
    w_clr       = 3'b000;
    w_start     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_pick != TYPE_NONE) begin
          w_start     = 1'b1;
          w_type_nxt  = w_pick;
          w_cnt_nxt   = CNT_W'(pulse_len(w_pick, COLD_PULSE, WARM_PULSE, DEBUG_PULSE) - 1);
          w_clr       = {w_pick == TYPE_DEBUG, w_pick == TYPE_WARM, w_pick == TYPE_COLD};
          w_state_nxt = ST_PULSE;
        end
      end
      ST_PULSE: begin
        if (r_cnt == '0) begin
          w_cnt_nxt   = CNT_W'(HOLDOFF - 1);
          w_type_nxt  = TYPE_NONE;
          w_state_nxt = ST_HOLDOFF;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      ST_HOLDOFF: begin
        if (r_cnt == '0) w_state_nxt = ST_IDLE;
        else             w_cnt_nxt   = r_cnt - 1'b1;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Outputs are flopped from the next-state view so they line up with the
  // state register without any decode after the flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      cold_req_n  <= 1'b1;
      warm_req_n  <= 1'b1;
      debug_req_n <= 1'b1;
      busy        <= 1'b0;
      active_type <= TYPE_NONE;
    end else begin
      cold_req_n  <= !(w_state_nxt == ST_PULSE && w_type_nxt == TYPE_COLD);
      warm_req_n  <= !(w_state_nxt == ST_PULSE && w_type_nxt == TYPE_WARM);
      debug_req_n <= !(w_state_nxt == ST_PULSE && w_type_nxt == TYPE_DEBUG);
      busy        <= (w_state_nxt != ST_IDLE);
      active_type <= (w_state_nxt == ST_PULSE) ? w_type_nxt : TYPE_NONE;
    end
  end

`ifdef RESET_SEQ_COUNTERS_EN
  logic [2:0][7:0] r_req_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_req_cnt <= '0;
    end else if (w_start) begin
      for (int i = 0; i < 3; i++) begin
        if (w_clr[i] && r_req_cnt[i] != 8'hFF) r_req_cnt[i] <= r_req_cnt[i] + 8'd1;
      end
    end
  end

  assign req_cnt = r_req_cnt;
`endif

endmodule
`default_nettype wire
